// File: rtl/adc_spi_pkg.sv
// Shared constants and state type for the 3-wire ADC serial link.
package adc_spi_pkg;

  localparam int unsigned FRAME_LEN      = 16;
  localparam int unsigned LEAD_ZEROS     = 4;
  localparam int unsigned ADDR_POS_FIRST = 2;
  localparam int unsigned ADDR_W         = 3;
  localparam int unsigned CNT_W          = $clog2(FRAME_LEN);

  typedef enum logic {IDLE, ACTIVE} spiState_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchronizer with rise/fall detection on the last two synchronized samples.
module spi_edge_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iD,
  output logic oLEVEL,
  output logic oRISE_c,
  output logic oFALL_c
);

  logic [STAGES-1:0] syncQ;
  logic              prevQ;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      syncQ <= {STAGES{RST_VAL}};
      prevQ <= RST_VAL;
    end else begin
      syncQ <= {syncQ[STAGES-2:0], iD};
      prevQ <= syncQ[STAGES-1];
    end
  end

  assign oLEVEL  = syncQ[STAGES-1];
  assign oRISE_c = oLEVEL & ~prevQ;
  assign oFALL_c = ~oLEVEL & prevQ;

endmodule

// File: rtl/adc_spi_responder.sv
// Emulates the 8-channel 12-bit SPI ADC: decodes the channel address on DIN and
// shifts the previously addressed channel's sample out on DOUT.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned CH_NUM      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iCS_n,
  input  logic                     iSCLK,
  input  logic                     iDIN,
  input  logic [CH_NUM*DATA_W-1:0] iSAMPLE,
  output logic                     oDOUT,
  output logic [ADDR_W-1:0]        oADDR,
  output logic                     oFRAME_DONE,
  output logic                     oABORT,
  output logic                     oBUSY
);

  localparam int unsigned AIDX_W = $clog2(ADDR_W);

  logic csLevel, csRise, csFall;
  logic sclkLevel, sclkRise, sclkFall;
  logic dinLevel, dinRise, dinFall;
  logic unusedSync;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) uCsSync (
    .iCLK(iCLK), .iRST(iRST), .iD(iCS_n),
    .oLEVEL(csLevel), .oRISE_c(csRise), .oFALL_c(csFall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) uSclkSync (
    .iCLK(iCLK), .iRST(iRST), .iD(iSCLK),
    .oLEVEL(sclkLevel), .oRISE_c(sclkRise), .oFALL_c(sclkFall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) uDinSync (
    .iCLK(iCLK), .iRST(iRST), .iD(iDIN),
    .oLEVEL(dinLevel), .oRISE_c(dinRise), .oFALL_c(dinFall)
  );

  assign unusedSync = &{1'b0, csLevel, sclkLevel, dinRise, dinFall};

  spiState_t             state, stateNxt;
  logic [CNT_W-1:0]      bitCnt, bitCntNxt;
  logic [FRAME_LEN-1:0]  frameReg, frameNxt;
  logic [ADDR_W-1:0]     addrCap, addrCapNxt, addrNxt;
  logic                  doutNxt, doneNxt, abortNxt;
  logic [AIDX_W-1:0]     addrIdx;
  logic                  inAddrWin;

  // Frame word for a channel: leading zeros then the 12-bit sample, MSB first.
  function automatic logic [FRAME_LEN-1:0] frameFor(
    input logic [CH_NUM*DATA_W-1:0] sample,
    input logic [ADDR_W-1:0]        addr
  );
    return {{LEAD_ZEROS{1'b0}}, sample[int'(addr)*DATA_W +: DATA_W]};
  endfunction

  assign inAddrWin = (32'(bitCnt) >= ADDR_POS_FIRST) && (32'(bitCnt) < ADDR_POS_FIRST + ADDR_W);
  assign addrIdx   = AIDX_W'(ADDR_POS_FIRST + ADDR_W - 1 - 32'(bitCnt));

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state <= IDLE;
    else       state <= stateNxt;
  end

  // Next-state and datapath decisions; a CS_n rise pre-empts any same-cycle SCLK edge.
  always_comb begin
    stateNxt   = state;
    bitCntNxt  = bitCnt;
    frameNxt   = frameReg;
    addrCapNxt = addrCap;
    addrNxt    = oADDR;
    doutNxt    = oDOUT;
    doneNxt    = 1'b0;
    abortNxt   = 1'b0;
    case (state)
      IDLE: begin
        doutNxt   = 1'b0;
        bitCntNxt = '0;
        if (csFall) begin
          stateNxt = ACTIVE;
          frameNxt = frameFor(iSAMPLE, oADDR);
          doutNxt  = frameNxt[FRAME_LEN-1];
        end
      end
      ACTIVE: begin
        if (csRise) begin
          stateNxt  = IDLE;
          doutNxt   = 1'b0;
          bitCntNxt = '0;
          abortNxt  = (bitCnt != '0);
        end else if (sclkRise) begin
          if (inAddrWin) addrCapNxt[addrIdx] = dinLevel;
          if (bitCnt == CNT_W'(FRAME_LEN-1)) begin
            addrNxt   = addrCapNxt;
            doneNxt   = 1'b1;
            frameNxt  = frameFor(iSAMPLE, addrCapNxt);
            bitCntNxt = '0;
          end else begin
            bitCntNxt = bitCnt + CNT_W'(1);
          end
        end else if (sclkFall) begin
          // Indexed by rising edges seen so far, so a leading SCLK fall still presents position 1.
          doutNxt = frameReg[CNT_W'(FRAME_LEN-1) - bitCnt];
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      bitCnt      <= '0;
      frameReg    <= '0;
      addrCap     <= '0;
      oADDR       <= '0;
      oDOUT       <= 1'b0;
      oFRAME_DONE <= 1'b0;
      oABORT      <= 1'b0;
      oBUSY       <= 1'b0;
    end else begin
      bitCnt      <= bitCntNxt;
      frameReg    <= frameNxt;
      addrCap     <= addrCapNxt;
      oADDR       <= addrNxt;
      oDOUT       <= doutNxt;
      oFRAME_DONE <= doneNxt;
      oABORT      <= abortNxt;
      oBUSY       <= (stateNxt == ACTIVE);
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: SCLK = iCLK/8, DOUT sampled at each SCLK rise.
module tb_adc_spi_responder;

  logic        clk = 1'b0;
  logic        rstN;
  logic        csN;
  logic        sclk;
  logic        din;
  logic [95:0] sample;
  logic        dout;
  logic [2:0]  addrOut;
  logic        frameDone;
  logic        abortP;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int doneCnt = 0;
  int abortCnt = 0;

  typedef struct {
    logic [2:0]  addrSent;
    logic [15:0] expWord;
    logic [2:0]  expAddr;
  } frameVec_t;

  frameVec_t vecs [7];

  adc_spi_responder dut (
    .iCLK(clk), .iRST(rstN), .iCS_n(csN), .iSCLK(sclk), .iDIN(din),
    .iSAMPLE(sample), .oDOUT(dout), .oADDR(addrOut),
    .oFRAME_DONE(frameDone), .oABORT(abortP), .oBUSY(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frameDone) doneCnt++;
    if (abortP) abortCnt++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic setCh(input int ch, input logic [11:0] val);
    sample[ch*12 +: 12] = val;
  endtask

  // Drives nRises SCLK periods (fall then rise), optionally changing one channel at a position.
  task automatic runFrame(input int nRises, input logic [2:0] addrSent, input int chgPos,
                          input int chgCh, input logic [11:0] chgVal, output logic [15:0] got);
    got = '0;
    for (int i = 0; i < nRises; i++) begin
      sclk = 1'b0;
      din  = (i >= 2 && i <= 4) ? addrSent[4-i] : 1'b0;
      if (i == chgPos) setCh(chgCh, chgVal);
      repeat (4) @(negedge clk);
      got[15-i] = dout;
      sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    logic [15:0] word;
    int doneBefore;
    int abortBefore;

    vecs[0] = '{3'd5, 16'h0ABC, 3'd5};
    vecs[1] = '{3'd2, 16'h0123, 3'd2};
    vecs[2] = '{3'd7, 16'h05A5, 3'd7};
    vecs[3] = '{3'd0, 16'h0FED, 3'd0};
    vecs[4] = '{3'd3, 16'h0ABC, 3'd3};
    vecs[5] = '{3'd4, 16'h03C3, 3'd4};
    vecs[6] = '{3'd5, 16'h0444, 3'd5};

    sample = '0;
    setCh(0, 12'hABC); setCh(1, 12'h0C0); setCh(2, 12'h5A5); setCh(3, 12'h3C3);
    setCh(4, 12'h444); setCh(5, 12'h123); setCh(6, 12'h666); setCh(7, 12'hFED);
    rstN = 1'b0; csN = 1'b1; sclk = 1'b1; din = 1'b0;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (4) @(negedge clk);

    check("reset dout", 32'(dout), 32'd0);
    check("reset addr", 32'(addrOut), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(frameDone), 32'd0);
    check("reset abort", 32'(abortP), 32'd0);

    csN = 1'b0;
    repeat (4) @(negedge clk);
    check("busy after cs fall", 32'(busy), 32'd1);

    // Back-to-back frames with CS_n held low; each frame returns the previous address's channel.
    for (int r = 0; r < 7; r++) begin
      doneBefore = doneCnt;
      runFrame(16, vecs[r].addrSent, -1, 0, 12'h0, word);
      check($sformatf("row%0d dout", r), 32'(word), 32'(vecs[r].expWord));
      check($sformatf("row%0d addr", r), 32'(addrOut), 32'(vecs[r].expAddr));
      check($sformatf("row%0d done pulses", r), 32'(doneCnt - doneBefore), 32'd1);
    end

    // Sample change mid-frame must not disturb the latched word.
    runFrame(16, 3'd5, 7, 5, 12'hFFF, word);
    check("midchange dout", 32'(word), 32'h0123);
    runFrame(16, 3'd5, -1, 0, 12'h0, word);
    check("after change dout", 32'(word), 32'h0FFF);
    check("after change addr", 32'(addrOut), 32'd5);

    // Abort after 9 rising edges.
    doneBefore  = doneCnt;
    abortBefore = abortCnt;
    runFrame(9, 3'd6, -1, 0, 12'h0, word);
    csN = 1'b1;
    repeat (6) @(negedge clk);
    check("abort pulses", 32'(abortCnt - abortBefore), 32'd1);
    check("abort no done", 32'(doneCnt - doneBefore), 32'd0);
    check("abort addr kept", 32'(addrOut), 32'd5);
    check("abort dout", 32'(dout), 32'd0);
    check("abort busy", 32'(busy), 32'd0);

    csN = 1'b0;
    repeat (4) @(negedge clk);
    runFrame(16, 3'd1, -1, 0, 12'h0, word);
    check("restart dout", 32'(word), 32'h0FFF);
    check("restart addr", 32'(addrOut), 32'd1);

    // Reset asserted at position 10 of a frame carrying ch1 = 0x0C0.
    runFrame(10, 3'd3, -1, 0, 12'h0, word);
    check("pre-reset dout", 32'(dout), 32'd1);
    rstN = 1'b0;
    #1;
    check("midreset dout", 32'(dout), 32'd0);
    check("midreset addr", 32'(addrOut), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(frameDone), 32'd0);
    check("midreset abort", 32'(abortP), 32'd0);
    csN = 1'b1; sclk = 1'b1;
    repeat (4) @(negedge clk);
    rstN = 1'b1;
    repeat (4) @(negedge clk);

    csN = 1'b0;
    repeat (4) @(negedge clk);
    runFrame(16, 3'd2, -1, 0, 12'h0, word);
    check("post-reset dout", 32'(word), 32'h0ABC);
    check("post-reset addr", 32'(addrOut), 32'd2);
    runFrame(16, 3'd2, -1, 0, 12'h0, word);
    check("ch2 second frame", 32'(word), 32'h05A5);
    csN = 1'b1;
    repeat (6) @(negedge clk);
    check("final busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

Synthesizable responder end of the 3-wire ADC serial link: emulates the 8-channel, 12-bit SPI ADC that the ADC controller drives, so the receiver chain can run in hardware loopback and simulation without the physical converter. It oversamples the controller's CS_n/SCLK/DIN on the system clock, decodes the 3-bit channel address, and shifts the selected channel's 12-bit sample out on DOUT. It sits on the board-side pins of the controller, between the controller and a sample source (test pattern generator or the VPPM channel model).

## Interface
- DATA_W, 12: sample width in bits.
- CH_NUM, 8: number of channels; fixed 3-bit address.
- SYNC_STAGES, 2: synchronizer depth on iCS_n/iSCLK/iDIN, minimum 2.
- iCLK  in  1  system clock; must be ≥8× SCLK frequency.
- iRST  in  1  reset, asynchronous, active-low.
- iCS_n  in  1  chip select from controller, active-low.
- iSCLK  in  1  serial clock from controller; idles high.
- iDIN  in  1  address bits from controller.
- iSAMPLE  in  CH_NUM*DATA_W  flat sample bus; channel n at [n*DATA_W +: DATA_W].
- oDOUT  out  1  serial data to controller.
- oADDR  out  3  address captured in last completed frame.
- oFRAME_DONE  out  1  one-cycle pulse when a 16-bit frame completes.
- oABORT  out  1  one-cycle pulse when CS_n rises mid-frame.
- oBUSY  out  1  high while CS_n (synchronized) is low.

## Operation
- Frame = 16 SCLK periods, MSB first. Positions 1..16 counted by SCLK rising edges (4-bit bit_cnt, 0..15).
- DIN: sampled on synchronized rising edges; positions 3, 4, 5 → ADD2, ADD1, ADD0. Other positions ignored.
- DOUT: positions 1..4 are 0, positions 5..16 are sample bits 11..0. Changes only on synchronized SCLK falling edges, or on CS_n fall (position 1).
- Pipelined addressing, as on the real part: frame N outputs the channel addressed in frame N−1. First frame after CS_n falls uses the address held in oADDR (0 after reset).
- Sample latch: the 16-bit shift register is loaded with {4'b0, iSAMPLE[addr]} at CS_n fall and at every 16th rising edge. Later iSAMPLE changes do not affect the frame in flight.
- Continuous frames: with CS_n held low, bit_cnt wraps 15→0 and the next frame starts with no gap.
- FSM: IDLE (CS_n high; DOUT=0, bit_cnt=0) → ACTIVE on synchronized CS_n fall.
  - ACTIVE → IDLE on CS_n rise.
  - If bit_cnt≠0 at that rise, pulse oABORT and leave oADDR unchanged.
- 16th rising edge: oADDR ← captured address, pulse oFRAME_DONE, reload the shift register.
- Simultaneous SCLK edge and CS_n rise in the same iCLK cycle: the CS_n rise wins and the edge is discarded.
- Reset (any time, including mid-frame): oDOUT=0, oADDR=0, oFRAME_DONE=0, oABORT=0, oBUSY=0, FSM=IDLE, bit_cnt=0.

## Timing
- Input-to-decision latency: SYNC_STAGES+1 iCLK cycles; edge detection compares the last two synchronized samples.
- oDOUT updates registered, ≤SYNC_STAGES+1 iCLK cycles after the SCLK falling edge. With iCLK ≥8× SCLK, this is stable well before the controller's next rising-edge sample.
- oFRAME_DONE and oADDR update in the same iCLK cycle, SYNC_STAGES+1 cycles after the 16th rising edge.
- oBUSY follows synchronized CS_n low with SYNC_STAGES+1 cycles latency.

## Structure
- Package adc_spi_pkg holds:
  - FRAME_LEN=16, LEAD_ZEROS=4, ADDR_POS_FIRST=2 (0-based bit_cnt), ADDR_W=3.
  - FSM state typedef {IDLE, ACTIVE}.
  - Shared by the controller testbench.
- Sub-module spi_edge_sync: parameterized synchronizer plus rise/fall detector. Instanced for iSCLK and iCS_n; iDIN uses the synchronizer only.

## Test plan
- Reset, then one frame at SCLK=iCLK/8 with DIN address 3'b101 and iSAMPLE ch0=12'hABC → DOUT 0000_1010_1011_1100; oADDR=5 and one oFRAME_DONE pulse.
- Second frame back-to-back, CS_n held low, ch5=12'h123 → DOUT 0000_0001_0010_0011; no gap; bit_cnt wraps.
- iSAMPLE ch5 changed to 12'hFFF at position 8 of the frame → frame still shifts 12'h123; next frame shifts 12'hFFF.
- CS_n raised after 9 rising edges → one oABORT pulse, oADDR unchanged, DOUT=0; next frame restarts at position 1.
- iRST asserted at position 10 → all outputs 0 within one cycle; first frame after release outputs channel 0.
- Run the real ADC controller against this block with iCH=3'b010, ch2=12'h5A5 → controller's 12-bit result reads 12'h5A5 from the second frame on.
